// File: rtl/alu_seq_if.sv
// Pushbutton/switch command inputs and display-side outputs of the sequential ALU.
// The master modport drives commands; the slave modport is the ALU.
interface alu_seq_if #(
    parameter int unsigned W = 8
);
    logic           pb1_db;
    logic           pb2_db;
    logic           pb3_db;
    logic [W-1:0]   sw;
    logic [2*W-1:0] result;
    logic [3:0]     flags;
    logic [3:0]     letters;
    logic           busy;
    logic           done;

    modport master (
        output pb1_db, pb2_db, pb3_db, sw,
        input  result, flags, letters, busy, done
    );

    modport slave (
        input  pb1_db, pb2_db, pb3_db, sw,
        output result, flags, letters, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// W-bit sequential ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide behind a busy/done handshake.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input logic      clk,
    input logic      rstn,
    alu_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [3:0]     op_q, op_d, flags_q, flags_d, letters_q, letters_d;
    logic [2*W-1:0] res_q, res_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic [SW-1:0]  sh;
    logic [W:0]     add_w, sub_w, shl_w, shr_w, sar_w;
    logic [W-1:0]   neg_w, alu_r;
    logic           alu_hi, alu_c, alu_v;

    logic [W:0]     mul_sum, div_sh, div_sub;
    logic [2*W-1:0] mul_prod;
    logic [W-1:0]   div_rem, div_quo;
    logic           div_ge;

    assign sh    = b_q[SW-1:0];
    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};
    assign neg_w = ~a_q + W'(1);
    // One extra bit on the shifted-out side captures the last bit lost
    assign shl_w = {1'b0, a_q} << sh;
    assign shr_w = {a_q, 1'b0} >> sh;
    assign sar_w = $signed({a_q, 1'b0}) >>> sh;

    // Multiply: {hi,lo} starts as {0,B}; add A into hi on lo[0], then shift right
    assign mul_sum  = {1'b0, hi_q} + {1'b0, lo_q[0] ? a_q : {W{1'b0}}};
    assign mul_prod = {mul_sum, lo_q[W-1:1]};
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in
    assign div_sh   = {hi_q, lo_q[W-1]};
    assign div_sub  = div_sh - {1'b0, b_q};
    assign div_ge   = ~div_sub[W];
    assign div_rem  = div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
    assign div_quo  = {lo_q[W-2:0], div_ge};

    always_comb begin
        alu_r  = '0;
        alu_hi = 1'b0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (bus.sw[3:0])
            4'h1, 4'hE: begin
                alu_r  = add_w[W-1:0];
                alu_hi = add_w[W];
                alu_c  = add_w[W];
                alu_v  = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
            end
            4'h2, 4'hD: begin
                alu_r  = sub_w[W-1:0];
                alu_hi = sub_w[W];
                alu_c  = sub_w[W];
                alu_v  = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
            end
            4'h3: begin
                alu_r = neg_w;
                alu_v = (a_q == {1'b1, {(W-1){1'b0}}});
            end
            4'h4: alu_r = a_q & b_q;
            4'h5: alu_r = a_q | b_q;
            4'h6: alu_r = a_q ^ b_q;
            4'h7: alu_r = ~a_q;
            4'h8: begin
                alu_r = shl_w[W-1:0];
                alu_c = shl_w[W];
            end
            4'h9: begin
                alu_r = shr_w[W:1];
                alu_c = shr_w[0];
            end
            4'hA: begin
                alu_r = sar_w[W:1];
                alu_c = sar_w[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        flags_d   = flags_q;
        letters_d = letters_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.pb1_db) begin
                    a_d       = bus.sw;
                    letters_d = 4'hA;
                end else if (bus.pb2_db) begin
                    b_d       = bus.sw;
                    letters_d = 4'hB;
                end else if (bus.pb3_db) begin
                    op_d = bus.sw[3:0];
                    case (bus.sw[3:0])
                        4'h0: ;
                        4'hB: begin
                            state_d   = StMul;
                            busy_d    = 1'b1;
                            letters_d = 4'hF;
                            hi_d      = '0;
                            lo_d      = b_q;
                            cnt_d     = '0;
                        end
                        4'hC: begin
                            if (b_q == '0) begin
                                res_d     = {a_q, {W{1'b1}}};
                                flags_d   = 4'b0000;
                                letters_d = 4'hE;
                                done_d    = 1'b1;
                            end else begin
                                state_d   = StDiv;
                                busy_d    = 1'b1;
                                letters_d = 4'hF;
                                hi_d      = '0;
                                lo_d      = a_q;
                                cnt_d     = '0;
                            end
                        end
                        4'hD: begin
                            flags_d   = {alu_r == '0, alu_r[W-1], alu_c, alu_v};
                            letters_d = 4'hD;
                            done_d    = 1'b1;
                        end
                        4'hF: begin
                            res_d     = '0;
                            flags_d   = 4'b0000;
                            letters_d = 4'hE;
                            done_d    = 1'b1;
                        end
                        default: begin
                            res_d     = {{(W-1){1'b0}}, alu_hi, alu_r};
                            flags_d   = {alu_r == '0, alu_r[W-1], alu_c, alu_v};
                            letters_d = bus.sw[3:0];
                            done_d    = 1'b1;
                            if (bus.sw[3:0] == 4'hE) a_d = alu_r;
                        end
                    endcase
                end
            end
            StMul: begin
                hi_d = mul_sum[W:1];
                lo_d = {mul_sum[0], lo_q[W-1:1]};
                if (cnt_q == SW'(W - 1)) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    res_d     = mul_prod;
                    flags_d   = {mul_prod == '0, mul_prod[2*W-1], 2'b00};
                    letters_d = op_q;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            StDiv: begin
                hi_d = div_rem;
                lo_d = div_quo;
                if (cnt_q == SW'(W - 1)) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    res_d     = {div_rem, div_quo};
                    flags_d   = {div_quo == '0, div_quo[W-1], 2'b00};
                    letters_d = op_q;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            letters_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            letters_q <= letters_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.result  = res_q;
    assign bus.flags   = flags_q;
    assign bus.letters = letters_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=8; each task checks its own scenario.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rstn;
    int   tests_run = 0;
    int   tests_failed = 0;

    alu_seq_if #(.W(8)) bus ();

    alu_seq #(.W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        bus.sw = v; bus.pb1_db = 1'b1; tick(); bus.pb1_db = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.sw = v; bus.pb2_db = 1'b1; tick(); bus.pb2_db = 1'b0;
    endtask

    task automatic exec(input logic [3:0] op);
        bus.sw = {4'h0, op}; bus.pb3_db = 1'b1; tick(); bus.pb3_db = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; tick(); tick(); rstn = 1'b0;
        tests_run++;
        if ({bus.result, bus.flags, bus.letters, bus.busy, bus.done} !== 26'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got res=%h fl=%b let=%h busy=%b done=%b, want all 0",
                     bus.result, bus.flags, bus.letters, bus.busy, bus.done);
        end
    endtask

    task automatic test_add();
        load_a(8'hFF); load_b(8'h01); exec(4'h1);
        tests_run++;
        if ({bus.result, bus.flags, bus.letters, bus.done} !== {16'h0100, 4'b1010, 4'h1, 1'b1}) begin
            tests_failed++;
            $display("FAIL add_carry: got res=%h fl=%b let=%h done=%b, want 0100 1010 1 1",
                     bus.result, bus.flags, bus.letters, bus.done);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_done_pulse: got done=%b, want 0", bus.done);
        end
        load_a(8'h7F); exec(4'h1);
        tests_run++;
        if ({bus.result, bus.flags} !== {16'h0080, 4'b0101}) begin
            tests_failed++;
            $display("FAIL add_overflow: got res=%h fl=%b, want 0080 0101", bus.result, bus.flags);
        end
    endtask

    task automatic test_sub_neg();
        load_a(8'h05); load_b(8'h07); exec(4'h2);
        tests_run++;
        if ({bus.result, bus.flags} !== {16'h01FE, 4'b0110}) begin
            tests_failed++;
            $display("FAIL sub_borrow: got res=%h fl=%b, want 01fe 0110", bus.result, bus.flags);
        end
        load_a(8'h80); exec(4'h3);
        tests_run++;
        if ({bus.result, bus.flags, bus.letters} !== {16'h0080, 4'b0101, 4'h3}) begin
            tests_failed++;
            $display("FAIL neg_min: got res=%h fl=%b let=%h, want 0080 0101 3",
                     bus.result, bus.flags, bus.letters);
        end
    endtask

    task automatic test_shifts();
        load_a(8'h81); load_b(8'h01);
        exec(4'h8);
        tests_run++;
        if ({bus.result, bus.flags} !== {16'h0002, 4'b0010}) begin
            tests_failed++;
            $display("FAIL shl: got res=%h fl=%b, want 0002 0010", bus.result, bus.flags);
        end
        exec(4'h9);
        tests_run++;
        if ({bus.result, bus.flags} !== {16'h0040, 4'b0010}) begin
            tests_failed++;
            $display("FAIL shr: got res=%h fl=%b, want 0040 0010", bus.result, bus.flags);
        end
        exec(4'hA);
        tests_run++;
        if ({bus.result, bus.flags} !== {16'h00C0, 4'b0110}) begin
            tests_failed++;
            $display("FAIL sar: got res=%h fl=%b, want 00c0 0110", bus.result, bus.flags);
        end
    endtask

    // Runs an already-accepted MUL/DIV to completion, counting busy cycles and done pulses.
    task automatic run_busy(input logic poke_a, output int busy_cyc, output int dones);
        busy_cyc = bus.busy ? 1 : 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 && poke_a) begin
                bus.sw = 8'h55; bus.pb1_db = 1'b1;
            end
            tick();
            bus.pb1_db = 1'b0;
            if (bus.done) dones++;
            if (!bus.busy) break;
            busy_cyc++;
        end
    endtask

    task automatic test_mul();
        int bc, dn;
        load_a(8'd200); load_b(8'd3); exec(4'hB);
        tests_run++;
        if ({bus.busy, bus.letters, bus.done} !== {1'b1, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_accept: got busy=%b let=%h done=%b, want 1 f 0",
                     bus.busy, bus.letters, bus.done);
        end
        run_busy(1'b1, bc, dn);
        tick();
        if (bus.done) dn++;
        tests_run++;
        if (bc != 8 || dn != 1) begin
            tests_failed++;
            $display("FAIL mul_timing: got busy_cycles=%0d dones=%0d, want 8 1", bc, dn);
        end
        tests_run++;
        if ({bus.result, bus.flags, bus.letters} !== {16'h0258, 4'b0000, 4'hB}) begin
            tests_failed++;
            $display("FAIL mul_result: got res=%h fl=%b let=%h, want 0258 0000 b",
                     bus.result, bus.flags, bus.letters);
        end
        exec(4'h1);
        tests_run++;
        if (bus.result !== 16'h00CB) begin
            tests_failed++;
            $display("FAIL mul_a_frozen: got res=%h, want 00cb", bus.result);
        end
    endtask

    task automatic test_div();
        int bc, dn;
        load_a(8'd200); load_b(8'd7); exec(4'hC);
        run_busy(1'b0, bc, dn);
        tests_run++;
        if (bc != 8 || dn != 1 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_timing: got busy_cycles=%0d dones=%0d, want 8 1", bc, dn);
        end
        tests_run++;
        if ({bus.result, bus.flags, bus.letters} !== {16'h041C, 4'b0000, 4'hC}) begin
            tests_failed++;
            $display("FAIL div_result: got res=%h fl=%b let=%h, want 041c 0000 c",
                     bus.result, bus.flags, bus.letters);
        end
        load_b(8'd0); exec(4'hC);
        tests_run++;
        if ({bus.result, bus.flags, bus.letters, bus.busy, bus.done}
            !== {16'hC8FF, 4'b0000, 4'hE, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL div_zero: got res=%h fl=%b let=%h busy=%b done=%b, want c8ff 0000 e 0 1",
                     bus.result, bus.flags, bus.letters, bus.busy, bus.done);
        end
    endtask

    task automatic test_acc();
        logic [15:0] exp_res [3] = '{16'h0003, 16'h0005, 16'h0007};
        int dn = 0;
        load_a(8'd1); load_b(8'd2);
        bus.sw = 8'h0E; bus.pb3_db = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done) dn++;
            tests_run++;
            if (bus.result !== exp_res[i]) begin
                tests_failed++;
                $display("FAIL acc_step%0d: got res=%h, want %h", i, bus.result, exp_res[i]);
            end
        end
        bus.pb3_db = 1'b0;
        tick();
        if (bus.done) dn++;
        tests_run++;
        if (dn != 3) begin
            tests_failed++;
            $display("FAIL acc_dones: got %0d, want 3", dn);
        end
        exec(4'h1);
        tests_run++;
        if (bus.result !== 16'h0009) begin
            tests_failed++;
            $display("FAIL acc_a_value: got res=%h, want 0009", bus.result);
        end
    endtask

    task automatic test_misc();
        exec(4'h0);
        tests_run++;
        if ({bus.result, bus.done} !== {16'h0009, 1'b0}) begin
            tests_failed++;
            $display("FAIL nop: got res=%h done=%b, want 0009 0", bus.result, bus.done);
        end
        exec(4'hF);
        tests_run++;
        if ({bus.result, bus.flags, bus.letters, bus.done} !== {16'h0000, 4'b0000, 4'hE, 1'b1}) begin
            tests_failed++;
            $display("FAIL reserved: got res=%h fl=%b let=%h done=%b, want 0000 0000 e 1",
                     bus.result, bus.flags, bus.letters, bus.done);
        end
        bus.sw = 8'h01; bus.pb1_db = 1'b1; bus.pb3_db = 1'b1; tick();
        bus.pb1_db = 1'b0; bus.pb3_db = 1'b0;
        tests_run++;
        if ({bus.letters, bus.done} !== {4'hA, 1'b0}) begin
            tests_failed++;
            $display("FAIL priority: got let=%h done=%b, want a 0", bus.letters, bus.done);
        end
    endtask

    task automatic test_reset_mid_mul();
        load_a(8'd200); load_b(8'd3); exec(4'hB);
        tick(); tick();
        rstn = 1'b1; tick(); rstn = 1'b0;
        tests_run++;
        if ({bus.result, bus.flags, bus.letters, bus.busy, bus.done} !== 26'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: got res=%h fl=%b let=%h busy=%b done=%b, want all 0",
                     bus.result, bus.flags, bus.letters, bus.busy, bus.done);
        end
        tick();
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_no_done: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        exec(4'h1);
        tests_run++;
        if ({bus.result, bus.flags, bus.letters} !== {16'h0000, 4'b1000, 4'h1}) begin
            tests_failed++;
            $display("FAIL reset_operands: got res=%h fl=%b let=%h, want 0000 1000 1",
                     bus.result, bus.flags, bus.letters);
        end
    endtask

    initial begin
        bus.pb1_db = 1'b0;
        bus.pb2_db = 1'b0;
        bus.pb3_db = 1'b0;
        bus.sw     = '0;
        rstn       = 1'b1;
        test_reset();
        test_add();
        test_sub_neg();
        test_shifts();
        test_mul();
        test_div();
        test_acc();
        test_misc();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
